// File: rtl/mem_test_sequencer.sv
// Button-stepped memory exerciser: writes NUM_WORDS pattern words, then reads them back
// and counts mismatches. Each debounced key press advances one phase.
module mem_test_sequencer #(
    parameter int              SIZE         = 16,
    parameter int              NUM_WORDS    = 4,
    parameter logic [SIZE-1:0] ADDR_BASE    = 16'h0000,
    parameter logic [SIZE-1:0] PATTERN_SEED = 16'h1234,
    parameter logic [SIZE-1:0] PATTERN_STEP = 16'h1111,
    parameter int              DB_CYCLES    = 50000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stepButton,
    input  logic [SIZE-1:0] memReadData,
    output logic [SIZE-1:0] addr,
    output logic            we,
    output logic [SIZE-1:0] writeData,
    output logic [SIZE-1:0] lastRead,
    output logic [7:0]      errorCount,
    output logic [2:0]      state,
    output logic            done
);

    localparam int         DBW      = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);
    localparam logic [7:0] LAST_IDX = 8'(NUM_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_WRITE      = 3'd1,
        S_WRITE_WAIT = 3'd2,
        S_READ       = 3'd3,
        S_COMPARE    = 3'd4,
        S_READ_WAIT  = 3'd5,
        S_DONE       = 3'd6,
        S_ILLEGAL    = 3'd7
    } state_t;

    state_t          fsm;
    logic [7:0]      idx;
    logic            sync1, sync2;
    logic            db_level, db_prev;
    logic [DBW-1:0]  db_cnt;
    logic            step;

    // Key is active-low; all conditioning flops rest at 1 (released).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1    <= 1'b1;
            sync2    <= 1'b1;
            db_level <= 1'b1;
            db_prev  <= 1'b1;
            db_cnt   <= '0;
        end else begin
            sync1   <= stepButton;
            sync2   <= sync1;
            db_prev <= db_level;
            if (sync2 != db_level) begin
                if (db_cnt == DB_LAST) begin
                    db_level <= sync2;
                    db_cnt   <= '0;
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

    // step is a one-cycle pulse on a debounced press; the FSM consumes it only in
    // IDLE, WRITE_WAIT, READ_WAIT and DONE, so a pulse landing elsewhere is dropped.
    assign step  = db_prev & ~db_level;
    assign state = fsm;

    // addr/writeData track idx incrementally, so they are registered and never glitch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm        <= S_IDLE;
            idx        <= '0;
            addr       <= ADDR_BASE;
            writeData  <= PATTERN_SEED;
            we         <= 1'b0;
            lastRead   <= '0;
            errorCount <= '0;
            done       <= 1'b0;
        end else begin
            we <= 1'b0;
            case (fsm)
                S_IDLE: begin
                    done <= 1'b0;
                    if (step) begin
                        fsm        <= S_WRITE;
                        we         <= 1'b1;
                        errorCount <= '0;
                        lastRead   <= '0;
                    end
                end
                S_WRITE: fsm <= S_WRITE_WAIT;
                S_WRITE_WAIT: begin
                    if (step) begin
                        if (idx == LAST_IDX) begin
                            fsm       <= S_READ;
                            idx       <= '0;
                            addr      <= ADDR_BASE;
                            writeData <= PATTERN_SEED;
                        end else begin
                            fsm       <= S_WRITE;
                            we        <= 1'b1;
                            idx       <= idx + 1'b1;
                            addr      <= addr + 1'b1;
                            writeData <= writeData + PATTERN_STEP;
                        end
                    end
                end
                S_READ: fsm <= S_COMPARE;
                S_COMPARE: begin
                    lastRead <= memReadData;
                    if (memReadData != writeData && errorCount != 8'hFF)
                        errorCount <= errorCount + 1'b1;
                    fsm <= S_READ_WAIT;
                end
                S_READ_WAIT: begin
                    if (step) begin
                        if (idx == LAST_IDX) begin
                            fsm  <= S_DONE;
                            done <= 1'b1;
                        end else begin
                            fsm       <= S_READ;
                            idx       <= idx + 1'b1;
                            addr      <= addr + 1'b1;
                            writeData <= writeData + PATTERN_STEP;
                        end
                    end
                end
                S_DONE: begin
                    if (step) begin
                        fsm       <= S_IDLE;
                        done      <= 1'b0;
                        idx       <= '0;
                        addr      <= ADDR_BASE;
                        writeData <= PATTERN_SEED;
                    end
                end
                default: begin
                    fsm       <= S_IDLE;
                    done      <= 1'b0;
                    idx       <= '0;
                    addr      <= ADDR_BASE;
                    writeData <= PATTERN_SEED;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_test_sequencer.sv
// Directed bench for mem_test_sequencer: debounce, full write/read pass, fault memory,
// mid-pass async reset and address wrap-around.
module tb_mem_test_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        step_button = 1'b1;
    logic        bad = 1'b0;

    logic [15:0] rd, addr, wd, lr;
    logic        we, dn;
    logic [7:0]  ec;
    logic [2:0]  st;

    logic [15:0] rd_w, addr_w, wd_w, lr_w;
    logic        we_w, dn_w;
    logic [7:0]  ec_w;
    logic [2:0]  st_w;

    logic [15:0] mem   [0:65535];
    logic [15:0] mem_w [0:65535];

    logic [31:0] log_q[$];
    logic [31:0] log_w_q[$];
    logic [31:0] exp_q[$];
    logic        we_prev = 1'b0;
    int          double_we = 0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]  st;
        logic [15:0] ad;
        logic [15:0] wd;
        logic [7:0]  ec;
        logic [15:0] lr;
        logic        dn;
    } vec_t;
    vec_t tbl[10];

    always #5 clk = ~clk;

    mem_test_sequencer #(.DB_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .stepButton(step_button), .memReadData(rd),
        .addr(addr), .we(we), .writeData(wd), .lastRead(lr),
        .errorCount(ec), .state(st), .done(dn)
    );

    mem_test_sequencer #(.DB_CYCLES(4), .ADDR_BASE(16'hFFFE)) dut_w (
        .clk(clk), .reset(reset), .stepButton(step_button), .memReadData(rd_w),
        .addr(addr_w), .we(we_w), .writeData(wd_w), .lastRead(lr_w),
        .errorCount(ec_w), .state(st_w), .done(dn_w)
    );

    // Synchronous-read memory models; 'bad' makes address 0002 read back as zero.
    always @(posedge clk) begin
        if (we) mem[addr] <= wd;
        rd <= (bad && addr == 16'h0002) ? 16'h0000 : mem[addr];
        if (we_w) mem_w[addr_w] <= wd_w;
        rd_w <= mem_w[addr_w];
    end

    always @(negedge clk) begin
        if (we) log_q.push_back({addr, wd});
        if (we_w) log_w_q.push_back({addr_w, wd_w});
        if (we && we_prev) double_we++;
        we_prev = we;
    end

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic press();
        step_button = 1'b0;
        repeat (8) @(negedge clk);
        step_button = 1'b1;
        repeat (8) @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        log_q.delete();
        log_w_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{3'd2, 16'h0000, 16'h1234, 8'd0, 16'h0000, 1'b0};
        tbl[1] = '{3'd2, 16'h0001, 16'h2345, 8'd0, 16'h0000, 1'b0};
        tbl[2] = '{3'd2, 16'h0002, 16'h3456, 8'd0, 16'h0000, 1'b0};
        tbl[3] = '{3'd2, 16'h0003, 16'h4567, 8'd0, 16'h0000, 1'b0};
        tbl[4] = '{3'd5, 16'h0000, 16'h1234, 8'd0, 16'h1234, 1'b0};
        tbl[5] = '{3'd5, 16'h0001, 16'h2345, 8'd0, 16'h2345, 1'b0};
        tbl[6] = '{3'd5, 16'h0002, 16'h3456, 8'd0, 16'h3456, 1'b0};
        tbl[7] = '{3'd5, 16'h0003, 16'h4567, 8'd0, 16'h4567, 1'b0};
        tbl[8] = '{3'd6, 16'h0003, 16'h4567, 8'd0, 16'h4567, 1'b1};
        tbl[9] = '{3'd0, 16'h0000, 16'h1234, 8'd0, 16'h4567, 1'b0};

        // Reset state, button idle
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (50) @(negedge clk);
        #1;
        chk("rst_state", 32'(st), 32'd0);
        chk("rst_addr", 32'(addr), 32'h0000);
        chk("rst_we", 32'(we), 32'd0);
        chk("rst_wdata", 32'(wd), 32'h1234);
        chk("rst_errcnt", 32'(ec), 32'd0);
        chk("rst_lastread", 32'(lr), 32'd0);
        chk("rst_done", 32'(dn), 32'd0);
        chk("rst_no_writes", 32'(log_q.size()), 32'd0);

        // Short glitch shorter than the debounce window
        step_button = 1'b0;
        repeat (3) @(negedge clk);
        step_button = 1'b1;
        repeat (20) @(negedge clk);
        #1;
        chk("glitch_state", 32'(st), 32'd0);

        // Bounce then hold: exactly one step
        for (int i = 0; i < 20; i++) begin
            step_button = i[0];
            @(negedge clk);
        end
        step_button = 1'b0;
        repeat (20) @(negedge clk);
        step_button = 1'b1;
        repeat (20) @(negedge clk);
        #1;
        chk("bounce_state", 32'(st), 32'd2);
        chk("bounce_writes", 32'(log_q.size()), 32'd1);
        chk("bounce_addr", 32'(addr), 32'h0000);

        // Full pass with ideal memory, table driven
        do_reset();
        for (int i = 0; i < 10; i++) begin
            press();
            chk($sformatf("p%0d_state", i + 1), 32'(st), 32'(tbl[i].st));
            chk($sformatf("p%0d_addr", i + 1), 32'(addr), 32'(tbl[i].ad));
            chk($sformatf("p%0d_wdata", i + 1), 32'(wd), 32'(tbl[i].wd));
            chk($sformatf("p%0d_errcnt", i + 1), 32'(ec), 32'(tbl[i].ec));
            chk($sformatf("p%0d_lastread", i + 1), 32'(lr), 32'(tbl[i].lr));
            chk($sformatf("p%0d_done", i + 1), 32'(dn), 32'(tbl[i].dn));
            chk($sformatf("p%0d_we", i + 1), 32'(we), 32'd0);
        end
        exp_q = '{32'h0000_1234, 32'h0001_2345, 32'h0002_3456, 32'h0003_4567};
        chk("wr_count", 32'(log_q.size()), 32'd4);
        for (int i = 0; i < 4 && i < log_q.size(); i++)
            chk($sformatf("wr_%0d", i), log_q[i], exp_q[i]);
        chk("we_single_cycle", 32'(double_we), 32'd0);

        exp_q = '{32'hFFFE_1234, 32'hFFFF_2345, 32'h0000_3456, 32'h0001_4567};
        chk("wrap_count", 32'(log_w_q.size()), 32'd4);
        for (int i = 0; i < 4 && i < log_w_q.size(); i++)
            chk($sformatf("wrap_%0d", i), log_w_q[i], exp_q[i]);
        chk("wrap_errcnt", 32'(ec_w), 32'd0);
        chk("wrap_lastread", 32'(lr_w), 32'h4567);

        // Faulty memory at address 0002
        do_reset();
        bad = 1'b1;
        for (int i = 0; i < 9; i++) begin
            press();
            if (i == 5) chk("fault_ec_before", 32'(ec), 32'd0);
            if (i == 6) begin
                chk("fault_lastread", 32'(lr), 32'h0000);
                chk("fault_ec_at2", 32'(ec), 32'd1);
            end
        end
        chk("fault_ec_final", 32'(ec), 32'd1);
        chk("fault_state", 32'(st), 32'd6);
        chk("fault_done", 32'(dn), 32'd1);
        chk("fault_lastread_final", 32'(lr), 32'h4567);
        bad = 1'b0;

        // Asynchronous reset mid-pass in WRITE_WAIT with idx=2
        do_reset();
        repeat (3) press();
        chk("mid_state", 32'(st), 32'd2);
        chk("mid_addr", 32'(addr), 32'h0002);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("async_state", 32'(st), 32'd0);
        chk("async_addr", 32'(addr), 32'h0000);
        chk("async_we", 32'(we), 32'd0);
        chk("async_wdata", 32'(wd), 32'h1234);
        chk("async_done", 32'(dn), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        log_q.delete();
        press();
        chk("after_rst_writes", 32'(log_q.size()), 32'd1);
        if (log_q.size() > 0) chk("after_rst_wr0", log_q[0], 32'h0000_1234);
        chk("after_rst_state", 32'(st), 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
